// File: rtl/if_id_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the pipelined MIPS core.
// Owns the PC, handles stall/flush/redirect and halts fetch past the populated store.
module if_id_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          INST_WORDS = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic [0:0]  ST_RUN   = 1'b0;
    localparam logic [0:0]  ST_HALT  = 1'b1;
    localparam logic [31:0] PC_LIMIT = 32'(INST_WORDS * 4);
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;

    // Low address bits of a redirect target are discarded on purpose.
    logic unused_redirect_bits;
    assign unused_redirect_bits = &{1'b0, redirect_pc[1:0]};

    assign pc_plus4 = pc_q + 32'd4;

    // Rules are evaluated in strict priority; a bubble keeps ifid_pc/ifid_pc4.
    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no latch is inferred.
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        ifid_pc_d  = ifid_pc_q;
        ifid_pc4_d = ifid_pc4_q;
        valid_d    = valid_q;
        count_d    = count_q;

        if (redirect_i) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            inst_d  = NOP;
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (state_q == ST_HALT) begin
            inst_d  = NOP;
            valid_d = 1'b0;
        end else if (pc_q >= PC_LIMIT) begin
            inst_d  = NOP;
            valid_d = 1'b0;
            state_d = ST_HALT;
        end else if (stall_i && flush_i) begin
            inst_d  = NOP;
            valid_d = 1'b0;
        end else if (stall_i) begin
            // PC and IF/ID both hold, valid bit included.
        end else if (flush_i) begin
            pc_d    = pc_plus4;
            inst_d  = NOP;
            valid_d = 1'b0;
        end else begin
            inst_d     = imem_data;
            ifid_pc_d  = pc_q;
            ifid_pc4_d = pc_plus4;
            valid_d    = 1'b1;
            pc_d       = pc_plus4;
            count_d    = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            inst_q     <= NOP;
            ifid_pc_q  <= 32'h0;
            ifid_pc4_q <= 32'h0;
            valid_q    <= 1'b0;
            count_q    <= 32'h0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            ifid_pc_q  <= ifid_pc_d;
            ifid_pc4_q <= ifid_pc4_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign ifid_inst   = inst_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_pc4    = ifid_pc4_q;
    assign ifid_valid  = valid_q;
    assign halted      = (state_q == ST_HALT);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: free run, stall, flush, redirect, halt and async reset.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i, flush_i, redirect_i;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_data;
    logic [31:0] ifid_inst, ifid_pc, ifid_pc4, fetch_count;
    logic        ifid_valid, halted;

    int n_checks = 0;
    int n_pass   = 0;

    if_id_stage #(.RESET_PC(32'h0000_0000), .INST_WORDS(60)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .redirect_i (redirect_i),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .ifid_inst  (ifid_inst),
        .ifid_pc    (ifid_pc),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid),
        .halted     (halted),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory model: word tagged with its own address.
    assign imem_data = 32'h1000_0000 | imem_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_in(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
        stall_i     = st;
        flush_i     = fl;
        redirect_i  = rd;
        redirect_pc = rpc;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_addr"},  imem_addr,   32'h0);
        check({tag, "_inst"},  ifid_inst,   32'h0);
        check({tag, "_pc"},    ifid_pc,     32'h0);
        check({tag, "_pc4"},   ifid_pc4,    32'h0);
        check({tag, "_valid"}, {31'h0, ifid_valid}, 32'h0);
        check({tag, "_halt"},  {31'h0, halted},     32'h0);
        check({tag, "_cnt"},   fetch_count, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_reset_vals("rst");
        reset = 1'b0;

        // Free run: three consecutive captures.
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("run%0d_pc", i),    ifid_pc,  32'(i * 4));
            check($sformatf("run%0d_pc4", i),   ifid_pc4, 32'(i * 4 + 4));
            check($sformatf("run%0d_valid", i), {31'h0, ifid_valid}, 32'h1);
            check($sformatf("run%0d_inst", i),  ifid_inst, 32'h1000_0000 | 32'(i * 4));
            check($sformatf("run%0d_cnt", i),   fetch_count, 32'(i + 1));
        end
        check("pre_stall_addr", imem_addr, 32'h0C);

        // Two-cycle stall at PC 0x0C.
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("stall%0d_addr", i),  imem_addr, 32'h0C);
            check($sformatf("stall%0d_pc", i),    ifid_pc,   32'h08);
            check($sformatf("stall%0d_valid", i), {31'h0, ifid_valid}, 32'h1);
            check($sformatf("stall%0d_cnt", i),   fetch_count, 32'd3);
        end
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("post_stall_pc",  ifid_pc,     32'h0C);
        check("post_stall_cnt", fetch_count, 32'd4);
        check("post_stall_addr", imem_addr,  32'h10);

        // Flush with stall at PC 0x10, then flush alone.
        set_in(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        check("fl_st_valid", {31'h0, ifid_valid}, 32'h0);
        check("fl_st_inst",  ifid_inst, 32'h0);
        check("fl_st_addr",  imem_addr, 32'h10);
        check("fl_st_pc",    ifid_pc,   32'h0C);
        set_in(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check("flush_valid", {31'h0, ifid_valid}, 32'h0);
        check("flush_addr",  imem_addr, 32'h14);
        check("flush_cnt",   fetch_count, 32'd4);
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("post_flush_pc",  ifid_pc, 32'h14);
        check("post_flush_cnt", fetch_count, 32'd5);

        // Redirect beats stall and flush; low target bits dropped.
        set_in(1'b1, 1'b1, 1'b1, 32'h0000_0027);
        tick();
        check("redir_addr",  imem_addr, 32'h24);
        check("redir_valid", {31'h0, ifid_valid}, 32'h0);
        check("redir_inst",  ifid_inst, 32'h0);
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("redir_tgt_pc",    ifid_pc,   32'h24);
        check("redir_tgt_valid", {31'h0, ifid_valid}, 32'h1);
        check("redir_tgt_inst",  ifid_inst, 32'h1000_0024);
        check("redir_tgt_pc4",   ifid_pc4,  32'h28);
        check("redir_tgt_cnt",   fetch_count, 32'd6);

        // Run off the end: 0xEC is the last valid word, 0xF0 halts.
        set_in(1'b0, 1'b0, 1'b1, 32'h0000_00E8);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check("last_pc",    ifid_pc,   32'hEC);
        check("last_valid", {31'h0, ifid_valid}, 32'h1);
        check("last_addr",  imem_addr, 32'hF0);
        check("last_halt",  {31'h0, halted}, 32'h0);
        check("last_cnt",   fetch_count, 32'd8);
        tick();
        check("halt_flag",  {31'h0, halted}, 32'h1);
        check("halt_valid", {31'h0, ifid_valid}, 32'h0);
        check("halt_addr",  imem_addr, 32'hF0);
        check("halt_pc",    ifid_pc,   32'hEC);
        for (int i = 0; i < 3; i++) begin
            set_in(i != 1, i != 0, 1'b0, 32'h0);
            tick();
            check($sformatf("halt%0d_flag", i),  {31'h0, halted}, 32'h1);
            check($sformatf("halt%0d_valid", i), {31'h0, ifid_valid}, 32'h0);
            check($sformatf("halt%0d_addr", i),  imem_addr, 32'hF0);
            check($sformatf("halt%0d_cnt", i),   fetch_count, 32'd8);
        end
        set_in(1'b0, 1'b0, 1'b1, 32'h0000_002C);
        tick();
        check("unhalt_flag",  {31'h0, halted}, 32'h0);
        check("unhalt_addr",  imem_addr, 32'h2C);
        check("unhalt_valid", {31'h0, ifid_valid}, 32'h0);
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("unhalt_pc",    ifid_pc, 32'h2C);
        check("unhalt_valid2", {31'h0, ifid_valid}, 32'h1);
        check("unhalt_cnt",   fetch_count, 32'd9);

        // Async reset in a redirect bubble cycle, with another redirect pending.
        set_in(1'b1, 1'b1, 1'b1, 32'h0000_0027);
        tick();
        check("pre_arst_addr", imem_addr, 32'h24);
        set_in(1'b1, 1'b0, 1'b1, 32'h0000_0080);
        #2 reset = 1'b1;
        #1 check_reset_vals("arst");
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        tick();
        check("post_arst_pc",    ifid_pc,   32'h0);
        check("post_arst_valid", {31'h0, ifid_valid}, 32'h1);
        check("post_arst_inst",  ifid_inst, 32'h1000_0000);
        check("post_arst_cnt",   fetch_count, 32'd1);
        check("post_arst_addr",  imem_addr, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
